// File: rtl/ctrl_trace_encoder.sv
// Re-encodes the decode-stage control bundle into its MIPS opcode/funct pair,
// tags each entry with a sequence number and buffers it in a small drop-on-overflow FIFO.
module ctrl_trace_encoder #(
    parameter int DEPTH      = 4,
    parameter int SEQ_W      = 8,
    parameter int FILTER_NOP = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     reg_write,
    input  logic                     mem_to_reg,
    input  logic                     mem_write,
    input  logic                     alu_src,
    input  logic                     reg_dst,
    input  logic [3:0]               alu_control,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [5:0]               out_op,
    output logic [5:0]               out_funct,
    output logic                     out_err,
    output logic [SEQ_W-1:0]         out_seq,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 13 + SEQ_W;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [5:0]    enc_op;
    logic [5:0]    enc_funct;
    logic          enc_err;
    logic          all_zero;
    logic          push_try;
    logic          pop;
    logic          full;
    logic          accept;
    logic          drop;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [SEQ_W-1:0] seq_cnt;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;

    assign all_zero = ~|{reg_write, mem_to_reg, mem_write, alu_src, reg_dst, alu_control};

    // Inverse of the control-unit decode; unmatched bundles fall through to the error code.
    always_comb begin
        enc_op    = 6'h3F;
        enc_funct = 6'h3F;
        enc_err   = 1'b1;
        if (mem_write) begin
            enc_op = 6'h2B; enc_funct = 6'h00; enc_err = 1'b0;
        end else if (reg_write && mem_to_reg) begin
            enc_op = 6'h23; enc_funct = 6'h00; enc_err = 1'b0;
        end else if (reg_write && !alu_src && reg_dst) begin
            enc_err = 1'b0;
            enc_op  = 6'h00;
            case (alu_control)
                4'h1:    enc_funct = 6'h20;
                4'h7:    enc_funct = 6'h21;
                4'h2:    enc_funct = 6'h22;
                4'h8:    enc_funct = 6'h23;
                4'h3:    enc_funct = 6'h24;
                4'h4:    enc_funct = 6'h25;
                4'h5:    enc_funct = 6'h26;
                4'h6:    enc_funct = 6'h27;
                4'h9:    enc_funct = 6'h04;
                4'hA:    enc_funct = 6'h07;
                4'hB:    enc_funct = 6'h06;
                4'hC:    enc_funct = 6'h2A;
                4'hD:    enc_funct = 6'h2B;
                default: begin enc_op = 6'h3F; enc_funct = 6'h3F; enc_err = 1'b1; end
            endcase
        end else if (reg_write && alu_src && !reg_dst) begin
            enc_err   = 1'b0;
            enc_funct = 6'h00;
            case (alu_control)
                4'h1:    enc_op = 6'h08;
                4'h7:    enc_op = 6'h09;
                4'hC:    enc_op = 6'h0A;
                4'hD:    enc_op = 6'h0B;
                4'h3:    enc_op = 6'h0C;
                4'h4:    enc_op = 6'h0D;
                4'h5:    enc_op = 6'h0E;
                4'hE:    enc_op = 6'h0F;
                default: begin enc_op = 6'h3F; enc_funct = 6'h3F; enc_err = 1'b1; end
            endcase
        end else if (all_zero) begin
            enc_op = 6'h00; enc_funct = 6'h00; enc_err = 1'b0;
        end
    end

    assign push_try  = in_valid && !((FILTER_NOP != 0) && all_zero);
    assign out_valid = (level != '0);
    assign full      = (level == (AW+1)'(DEPTH));
    assign pop       = out_valid && out_ready;
    assign accept    = push_try && (!full || pop);
    assign drop      = push_try && full && !pop;

    // Control state: pointers, occupancy, sequence tag and drop bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            seq_cnt  <= '0;
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            if (accept && !pop)      level <= level + (AW+1)'(1);
            else if (!accept && pop) level <= level - (AW+1)'(1);
            if (push_try) seq_cnt <= seq_cnt + SEQ_W'(1);
            if (drop) begin
                overflow <= 1'b1;
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    // Entry storage carries data only, so it is left unreset.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= {enc_op, enc_funct, enc_err, seq_cnt};
    end

    assign head      = mem[rd_ptr];
    assign out_op    = out_valid ? head[EW-1 -: 6] : 6'h00;
    assign out_funct = out_valid ? head[EW-7 -: 6] : 6'h00;
    assign out_err   = out_valid ? head[SEQ_W]     : 1'b0;
    assign out_seq   = out_valid ? head[SEQ_W-1:0] : '0;

endmodule
